debug_word_encoder: RTL and testbench

- Transmit-side counterpart of the debugger command decoder in the MIPS debug unit.
- Accepts 32-bit debug values (PC, register-file entries, memory words) plus an 8-bit tag code.
- Serialises each value into a byte frame and feeds the frame one byte at a time to the UART transmitter via a start/done handshake.
- Sits between the debug unit's readout mux and the UART TX.

---
 rtl/debug_word_encoder_if.sv | 26 ++
 rtl/debug_word_encoder.sv | 116 +++++++++++
 tb/tb_debug_word_encoder.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_word_encoder_if.sv
// Bus between the debug readout side, the word encoder and the UART transmitter.
// The master modport belongs to the side that supplies words and returns tx_done.
// The slave modport belongs to the encoder.
interface debug_word_encoder_if #(
    parameter int WORD_WIDTH = 32
);
    logic [WORD_WIDTH-1:0] word_in;
    logic [7:0]            tag_in;
    logic                  word_valid;
    logic                  word_ready;
    logic [7:0]            tx_data;
    logic                  tx_start;
    logic                  tx_done;
    logic                  busy;
    logic                  frame_done;

    modport master (
        output word_in, tag_in, word_valid, tx_done,
        input  word_ready, tx_data, tx_start, busy, frame_done
    );

    modport slave (
        input  word_in, tag_in, word_valid, tx_done,
        output word_ready, tx_data, tx_start, busy, frame_done
    );
endinterface

// File: rtl/debug_word_encoder.sv
// Debug word encoder: turns one debug value (plus an optional tag byte) into a
// byte frame and hands it to the UART transmitter one byte at a time.
// The tag goes first, then the data word MSB first. Each byte is a tx_start
// pulse, followed by a wait for tx_done. A frame_done pulse closes the frame.
module debug_word_encoder #(
    parameter int WORD_WIDTH = 32,
    parameter bit SEND_TAG   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    debug_word_encoder_if.slave  bus
);
    localparam int NB    = WORD_WIDTH / 8 + (SEND_TAG ? 1 : 0);
    localparam int FW    = NB * 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [FW-1:0]          frame_load;
    logic [NB-1:0][7:0]     frame_order;
    logic [NB-1:0][7:0]     frame_q;
    logic                   accept;

    // Frame contents as they appear on the wire, tag (if any) in the top byte.
    generate
        if (SEND_TAG) begin : g_tag
            assign frame_load = {bus.tag_in, bus.word_in};
        end else begin : g_no_tag
            logic unused_tag;
            assign unused_tag = ^bus.tag_in;
            assign frame_load = bus.word_in;
        end
    endgenerate

    // Reorder so that frame byte k sits at array slot k and the index selects it directly.
    always_comb begin
        for (int k = 0; k < NB; k++) begin
            frame_order[k] = frame_load[FW-1-8*k -: 8];
        end
    end

    assign accept = bus.word_ready && bus.word_valid;

    // State and byte-index register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register here samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Latched frame. It is captured on accept only, so later word_in changes cannot reach the frame in flight.
    always_ff @(posedge clk) begin
        // NOTE: a plain data register would not need a reset. This one is cleared
        // because tx_data is read straight out of it and must be 00 after reset.
        if (reset) begin
            frame_q <= '0;
        end else if (accept) begin
            frame_q <= frame_order;
        end
    end

    // Next-state and index logic. tx_done is only honoured in WAIT.
    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no latch is inferred.
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    idx_d   = '0;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs. word_ready is also gated by reset, so nothing is accepted during a reset cycle.
    assign bus.word_ready = (state_q == IDLE) && !reset;
    assign bus.busy       = (state_q == ISSUE) || (state_q == WAIT);
    assign bus.tx_start   = (state_q == ISSUE);
    assign bus.frame_done = (state_q == DONE);
    assign bus.tx_data    = frame_q[idx_q];

endmodule

// File: tb/tb_debug_word_encoder.sv
// Directed bench for debug_word_encoder. Two instances (tag on, tag off) share
// the clock and reset. A cycle-by-cycle UART model answers each tx_start.
`timescale 1ns/1ps
module tb_debug_word_encoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic sel;
    int   checks   = 0;
    int   failures = 0;

    debug_word_encoder_if #(.WORD_WIDTH(32)) bt ();
    debug_word_encoder_if #(.WORD_WIDTH(32)) bn ();

    debug_word_encoder #(.WORD_WIDTH(32), .SEND_TAG(1'b1)) dut_t (
        .clk   (clk),
        .reset (reset),
        .bus   (bt.slave)
    );

    debug_word_encoder #(.WORD_WIDTH(32), .SEND_TAG(1'b0)) dut_n (
        .clk   (clk),
        .reset (reset),
        .bus   (bn.slave)
    );

    // Outputs of the instance under observation.
    logic       o_start, o_busy, o_ready, o_fd;
    logic [7:0] o_data;
    assign o_start = sel ? bn.tx_start   : bt.tx_start;
    assign o_busy  = sel ? bn.busy       : bt.busy;
    assign o_ready = sel ? bn.word_ready : bt.word_ready;
    assign o_fd    = sel ? bn.frame_done : bt.frame_done;
    assign o_data  = sel ? bn.tx_data    : bt.tx_data;

    // Observations gathered by observe_frame.
    logic [7:0] got [8];
    int   starts, first_start, fd_count, fd_cyc, last_done, prev_done;
    bit   hold_bad, busy_bad, ready_bad, gap_bad, timed_out, done_ready_bad;
    logic ready_after;

    task automatic set_done(input logic v);
        if (sel) bn.tx_done = v; else bt.tx_done = v;
    endtask

    task automatic set_valid(input logic v);
        if (sel) bn.word_valid = v; else bt.word_valid = v;
    endtask

    task automatic set_word(input logic [31:0] w, input logic [7:0] t);
        bt.word_in = w;
        bn.word_in = w;
        bt.tag_in  = t;
        bn.tag_in  = t;
    endtask

    // Caller is at a negedge in IDLE. The word is offered for one cycle.
    task automatic start_frame(input logic [31:0] w, input logic [7:0] t);
        set_word(w, t);
        set_valid(1'b1);
        @(negedge clk);
        set_valid(1'b0);
    endtask

    // UART model and recorder. c=0 is the cycle after the accept edge. tx_done is
    // returned lat cycles after each tx_start. spur_k>0 adds an extra tx_done
    // coincident with that start. stop_dones>0 returns right after that many tx_done.
    task automatic observe_frame(input int lat, input int spur_k, input int stop_dones,
                                 input int sw_cyc, input logic [31:0] sw_word);
        int         due;
        int         ndone;
        logic [7:0] cur;
        due = -1; ndone = 0; cur = 8'h00;
        starts = 0; first_start = -1; fd_count = 0; fd_cyc = -1;
        last_done = -1; prev_done = -1;
        hold_bad = 0; busy_bad = 0; ready_bad = 0; gap_bad = 0;
        timed_out = 0; done_ready_bad = 0; ready_after = 1'bx;
        for (int i = 0; i < 8; i++) got[i] = 8'hxx;
        for (int c = 0; c < 8000; c++) begin
            set_done(1'b0);
            if (c == sw_cyc) set_word(sw_word, 8'h38);
            if (o_fd === 1'b1) begin
                fd_count++;
                fd_cyc = c;
                if (o_ready !== 1'b0) done_ready_bad = 1;
                @(negedge clk);
                ready_after = o_ready;
                return;
            end
            if (o_start === 1'b1) begin
                if (starts < 8) got[starts] = o_data;
                starts++;
                if (first_start < 0) first_start = c;
                if (prev_done >= 0 && c != prev_done + 1) gap_bad = 1;
                cur = o_data;
                due = c + lat;
                if (starts == spur_k) set_done(1'b1);
            end else if (o_busy === 1'b1) begin
                if (o_data !== cur) hold_bad = 1;
            end
            if (o_busy === 1'b1 && o_ready !== 1'b0) ready_bad = 1;
            if (due >= 0 && o_busy !== 1'b1) busy_bad = 1;
            if (c == due) begin
                set_done(1'b1);
                due = -1;
                ndone++;
                prev_done = c;
                last_done = c;
                if (ndone == stop_dones) return;
            end
            @(negedge clk);
        end
        timed_out = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bt.word_ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready: got %b expected 0", bt.word_ready);
        end
        checks++;
        if ({bt.tx_start, bt.busy, bt.frame_done} !== 3'b000) begin
            failures++; $display("FAIL reset_ctrl: start/busy/fd got %b expected 000",
                                 {bt.tx_start, bt.busy, bt.frame_done});
        end
        checks++;
        if (bt.tx_data !== 8'h00 || bn.tx_data !== 8'h00) begin
            failures++; $display("FAIL reset_data: got %h/%h expected 00/00", bt.tx_data, bn.tx_data);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bt.word_ready !== 1'b1 || bt.busy !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset: ready/busy got %b%b expected 10",
                                 bt.word_ready, bt.busy);
        end
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp [5] = '{8'h38, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        sel = 1'b0;
        start_frame(32'hDEADBEEF, 8'h38);
        observe_frame(10, 0, 0, -1, 32'h0);
        checks++;
        if (timed_out) begin failures++; $display("FAIL basic_timeout: got timeout expected frame_done"); end
        checks++;
        if (starts !== 5) begin failures++; $display("FAIL basic_starts: got %0d expected 5", starts); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                failures++; $display("FAIL basic_byte%0d: got %h expected %h", i, got[i], exp[i]);
            end
        end
        checks++;
        if (first_start !== 0) begin failures++; $display("FAIL basic_first_start: got cycle %0d expected 0", first_start); end
        checks++;
        if (gap_bad) begin failures++; $display("FAIL basic_restart_gap: got gap != 1 expected 1"); end
        checks++;
        if (fd_count !== 1 || fd_cyc !== last_done + 1) begin
            failures++; $display("FAIL basic_frame_done: got count %0d at %0d expected 1 at %0d",
                                 fd_count, fd_cyc, last_done + 1);
        end
        checks++;
        if (ready_after !== 1'b1) begin failures++; $display("FAIL basic_ready_after: got %b expected 1", ready_after); end
        checks++;
        if (hold_bad || busy_bad || ready_bad || done_ready_bad) begin
            failures++; $display("FAIL basic_flags: hold/busy/ready/doneready got %b%b%b%b expected 0000",
                                 hold_bad, busy_bad, ready_bad, done_ready_bad);
        end
    endtask

    task automatic test_no_tag();
        logic [7:0] exp [4] = '{8'h00, 8'h40, 8'h00, 8'h10};
        sel = 1'b1;
        start_frame(32'h00400010, 8'h38);
        observe_frame(10, 0, 0, -1, 32'h0);
        checks++;
        if (starts !== 4 || timed_out) begin
            failures++; $display("FAIL notag_starts: got %0d (timeout %b) expected 4", starts, timed_out);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                failures++; $display("FAIL notag_byte%0d: got %h expected %h", i, got[i], exp[i]);
            end
        end
        checks++;
        if (fd_count !== 1 || fd_cyc !== last_done + 1) begin
            failures++; $display("FAIL notag_frame_done: got count %0d at %0d expected 1 at %0d",
                                 fd_count, fd_cyc, last_done + 1);
        end
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        set_word(32'h11111111, 8'h38);
        set_valid(1'b1);
        @(negedge clk);
        observe_frame(6, 0, 0, 15, 32'h22222222);
        checks++;
        if (starts !== 5 || timed_out) begin
            failures++; $display("FAIL bp_first_starts: got %0d (timeout %b) expected 5", starts, timed_out);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== ((i == 0) ? 8'h38 : 8'h11)) begin
                failures++; $display("FAIL bp_first_byte%0d: got %h expected %h", i, got[i],
                                     (i == 0) ? 8'h38 : 8'h11);
            end
        end
        checks++;
        if (ready_bad || done_ready_bad) begin
            failures++; $display("FAIL bp_ready_low: got ready high outside IDLE expected low");
        end
        checks++;
        if (ready_after !== 1'b1) begin failures++; $display("FAIL bp_ready_after: got %b expected 1", ready_after); end
        // word_valid is still high here, so the second word is taken on this IDLE cycle.
        @(negedge clk);
        set_valid(1'b0);
        observe_frame(6, 0, 0, -1, 32'h0);
        checks++;
        if (first_start !== 0 || starts !== 5) begin
            failures++; $display("FAIL bp_second_frame: got first %0d starts %0d expected 0 and 5",
                                 first_start, starts);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== ((i == 0) ? 8'h38 : 8'h22)) begin
                failures++; $display("FAIL bp_second_byte%0d: got %h expected %h", i, got[i],
                                     (i == 0) ? 8'h38 : 8'h22);
            end
        end
    endtask

    task automatic test_spurious_done();
        logic [7:0] exp [5] = '{8'h38, 8'h12, 8'h34, 8'h56, 8'h78};
        sel = 1'b0;
        set_done(1'b1);
        @(negedge clk);
        set_done(1'b0);
        checks++;
        if ({o_busy, o_start, o_ready} !== 3'b001) begin
            failures++; $display("FAIL spur_idle: busy/start/ready got %b expected 001", {o_busy, o_start, o_ready});
        end
        start_frame(32'h12345678, 8'h38);
        observe_frame(4, 1, 0, -1, 32'h0);
        checks++;
        if (starts !== 5 || fd_count !== 1 || timed_out) begin
            failures++; $display("FAIL spur_starts: got %0d starts %0d fd expected 5 and 1", starts, fd_count);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                failures++; $display("FAIL spur_byte%0d: got %h expected %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp [5] = '{8'h3F, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        sel = 1'b0;
        start_frame(32'hAABBCCDD, 8'h38);
        observe_frame(3, 0, 2, -1, 32'h0);
        @(negedge clk);
        set_done(1'b0);
        checks++;
        if (o_start !== 1'b1 || o_data !== 8'hBB) begin
            failures++; $display("FAIL abort_setup: start/data got %b/%h expected 1/bb", o_start, o_data);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_ready, o_start, o_busy, o_fd} !== 4'b0000 || o_data !== 8'h00) begin
            failures++; $display("FAIL abort_outputs: ready/start/busy/fd got %b data %h expected 0000 00",
                                 {o_ready, o_start, o_busy, o_fd}, o_data);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1) begin failures++; $display("FAIL abort_ready: got %b expected 1", o_ready); end
        start_frame(32'hCAFEF00D, 8'h3F);
        observe_frame(5, 0, 0, -1, 32'h0);
        checks++;
        if (starts !== 5 || timed_out) begin
            failures++; $display("FAIL abort_new_starts: got %0d (timeout %b) expected 5", starts, timed_out);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                failures++; $display("FAIL abort_new_byte%0d: got %h expected %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_slow_uart();
        logic [7:0] exp [5] = '{8'h38, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        sel = 1'b0;
        start_frame(32'h89ABCDEF, 8'h38);
        observe_frame(1000, 0, 0, -1, 32'h0);
        checks++;
        if (timed_out || fd_count !== 1) begin
            failures++; $display("FAIL slow_complete: got fd %0d (timeout %b) expected 1", fd_count, timed_out);
        end
        checks++;
        if (hold_bad || busy_bad) begin
            failures++; $display("FAIL slow_hold: hold/busy errors got %b%b expected 00", hold_bad, busy_bad);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                failures++; $display("FAIL slow_byte%0d: got %h expected %h", i, got[i], exp[i]);
            end
        end
    endtask

    initial begin
        sel = 1'b0;
        reset = 1'b1;
        bt.word_valid = 1'b0; bn.word_valid = 1'b0;
        bt.tx_done = 1'b0;    bn.tx_done = 1'b0;
        set_word(32'h0, 8'h00);
        test_reset();
        test_basic_frame();
        test_no_tag();
        test_back_to_back();
        test_spurious_done();
        test_reset_mid_frame();
        test_slow_uart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
